seven_seg_scan_decoder: RTL
===========================

Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart to the team's BCD-to-7-segment encoders.
- Watches a time-multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers the BCD value of every digit.
- Publishes a packed BCD word once the same frame has been seen MATCH_FRAMES times in a row.
- Used as a display monitor/scoreboard on the board and in system benches.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (1..8)
- SETTLE_CYC, 4, consecutive cycles a one-hot an must hold before seg is sampled (>=1)
- MATCH_FRAMES, 2, consecutive identical valid frames required before publishing (>=1)
- CNT_W, 8, width of the settle and match counters

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- seg  input  7  segment lines {g,f,e,d,c,b,a}, active-high (bit0 = a)
- an  input  NUM_DIGITS  digit enables, active-high; bit i selects digit i
- bcd_out  output  4*NUM_DIGITS  published digits; digit i is in bits [4i+3:4i]
- blank_mask  output  NUM_DIGITS  bit i set = digit i was blank in the published frame
- valid  output  1  one-cycle pulse when bcd_out/blank_mask update
- err  output  1  one-cycle pulse when a frame contained an illegal segment pattern

Behaviour:
- Reset (synchronous, active-high): bcd_out=0, blank_mask=0, valid=0, err=0, FSM=WAIT, counters=0, capture mask=0, frame buffers=0.
- Pattern decode, combinational, segment codes to BCD:
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111100→6, 0100111→7, 1111111→8, 1100111→9.
  - 0000000 → blank: BCD 4'hF, blank bit set.
  - Any other code → illegal.
- an is registered each cycle into an_q. "Stable" means an==an_q and an is exactly one-hot.
- FSM states:
  - WAIT: settle counter=0. Go to SETTLE when an is one-hot.
  - SETTLE: counter increments while stable. Any change of an, or an not one-hot, returns to WAIT with counter cleared. On the SETTLE_CYC-th consecutive stable cycle, capture seg for the selected digit and go to HELD.
  - HELD: no recapture. Leave to WAIT on any change of an.
- Capture:
  - Writes the decoded digit, blank flag and illegal flag for index i.
  - Sets capture-mask bit i.
  - A repeat capture of the same index before the frame completes overwrites it.
- Frame completion: the capture that makes the mask all-ones completes the frame (edge E).
  - At edge E+1 the frame is evaluated and the mask is cleared.
  - Any illegal digit in the frame: err=1 for one cycle, match counter=0, published outputs unchanged.
  - Frame equal to the previous valid frame (digits and blank flags): match counter increments, saturating at MATCH_FRAMES. Otherwise the match counter is set to 1.
  - Match counter (after update) >= MATCH_FRAMES: bcd_out/blank_mask load the frame and valid=1 for one cycle.
  - A qualifying frame therefore produces valid visible in the cycle after E+1. Every qualifying frame pulses valid, including repeats.
  - MATCH_FRAMES=1 publishes every legal frame.
- Simultaneous events: capture of the first digit of the next frame in cycle E+1 is legal. The mask clear happens first, then the new bit is set.
- Reset mid-frame discards partial captures and the match history.
- an = all-zeros (display off) or multi-hot: no capture, FSM held in WAIT. The partial frame is retained.
- Width rules:
  - Settle counter saturates at SETTLE_CYC.
  - CNT_W must hold max(SETTLE_CYC, MATCH_FRAMES); an assertion flags violations in simulation.

Decomposition:
- Shared package seven_seg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants (the same codes the encoders drive);
  - BCD_BLANK = 4'hF;
  - FSM state encoding {WAIT, SETTLE, HELD}.
- One natural sub-module: seven_seg_pattern_decode, the combinational pattern → {bcd[3:0], blank, illegal} lookup. Instantiated once, on the muxed seg.

Test Plan:
1. Legal scan: NUM_DIGITS=4, SETTLE_CYC=4, MATCH_FRAMES=2. Drive an=0001..1000 for 6 cycles each with seg=1001111,1111100,0100111,1100111, for two frames. Required: valid exactly once, at the end of frame 2, with bcd_out=16'h9763 and blank_mask=0; frame 1 gives no valid.
2. Glitch rejection: hold an=0010 for 3 cycles, then 0100. Required: no capture for digit 1, and the frame never completes until digit 1 is held >=4 cycles.
3. Illegal pattern: one frame has seg=1010101 on digit 2. Required: err pulse at frame evaluation, no valid, and the following legal frame alone does not publish (match count restarts).
4. Blank digit: digit 3 seg=0000000 for two frames. Required: valid with bcd_out[15:12]=4'hF and blank_mask=4'b1000.
5. Changing value: frames 1234,1234,1235. Required: valid after frame 2 with bcd_out=16'h1234; no valid after frame 3; bcd_out still 16'h1234.
6. Reset mid-frame: assert rst for 1 cycle after 2 captures. Required: all outputs 0 next cycle, and a full 2-frame sequence is needed before the next valid.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment codes, blank code and scan FSM states
package seven_seg_pkg;

  // Segment codes {g,f,e,d,c,b,a}, identical to what the encoders drive
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0100111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } scan_state_t;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// rtl/seven_seg_pattern_decode.sv - segment pattern to BCD/blank/illegal lookup
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       illegal
);

  // Exact-match lookup; anything that is not a digit or blank is illegal
  always_comb begin
    bcd     = 4'h0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - recovers BCD digits from a scanned 7-segment bus
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int MATCH_FRAMES = 2,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    valid,
  output logic                    err
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] MATCH_LIM   = CNT_W'(MATCH_FRAMES);
  localparam int CNT_NEED = (SETTLE_CYC > MATCH_FRAMES) ? SETTLE_CYC : MATCH_FRAMES;
  localparam bit CNT_FITS = (CNT_W >= 31) || (CNT_NEED < (1 << CNT_W));

  scan_state_t             state;
  logic [CNT_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        match_cnt;
  logic [CNT_W-1:0]        match_next;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   mask_next;
  logic                    frame_done;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0]   frame_blank;
  logic [NUM_DIGITS-1:0]   frame_ill;
  logic [4*NUM_DIGITS-1:0] prev_bcd;
  logic [NUM_DIGITS-1:0]   prev_blank;
  logic [3:0]              dec_bcd;
  logic                    dec_blank;
  logic                    dec_ill;
  logic                    an_onehot;
  logic                    stable;
  logic                    capture;
  logic                    frame_same;

  seven_seg_pattern_decode u_decode (
    .seg     (seg),
    .bcd     (dec_bcd),
    .blank   (dec_blank),
    .illegal (dec_ill)
  );

  // Qualify the digit enables, decide the capture cycle and the next match count
  always_comb begin
    an_onehot  = $onehot(an);
    stable     = an_onehot && (an == an_q);
    capture    = (state == ST_SETTLE) && stable && (settle_cnt >= SETTLE_LAST);
    // A frame evaluated this cycle clears the mask before the new capture bit lands
    mask_next  = (frame_done ? '0 : mask) | an;
    frame_same = (frame_bcd == prev_bcd) && (frame_blank == prev_blank);
    if (frame_same)
      match_next = (match_cnt >= MATCH_LIM) ? match_cnt : match_cnt + 1'b1;
    else
      match_next = CNT_W'(1);
  end

  // Scan FSM: wait for a one-hot enable, let it settle, capture once, hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT;
      settle_cnt <= '0;
      an_q       <= '0;
    end else begin
      an_q <= an;
      case (state)
        ST_WAIT: begin
          settle_cnt <= '0;
          if (an_onehot) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (!stable) begin
            state      <= ST_WAIT;
            settle_cnt <= '0;
          end else if (capture) begin
            state      <= ST_HELD;
            settle_cnt <= SETTLE_LIM;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (an != an_q) begin
            state      <= ST_WAIT;
            settle_cnt <= '0;
          end
        end
        default: begin
          state      <= ST_WAIT;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  // Frame buffers and capture mask; flags frame completion for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mask        <= '0;
      frame_done  <= 1'b0;
      frame_bcd   <= '0;
      frame_blank <= '0;
      frame_ill   <= '0;
    end else begin
      frame_done <= capture && (mask_next == '1);
      if (capture) begin
        mask <= mask_next;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an[i]) begin
            frame_bcd[4*i +: 4] <= dec_bcd;
            frame_blank[i]      <= dec_blank;
            frame_ill[i]        <= dec_ill;
          end
        end
      end else if (frame_done) begin
        mask <= '0;
      end
    end
  end

  // Evaluate a completed frame: reject illegal ones, count repeats, publish
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt  <= '0;
      prev_bcd   <= '0;
      prev_blank <= '0;
      bcd_out    <= '0;
      blank_mask <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (frame_done) begin
        if (|frame_ill) begin
          err       <= 1'b1;
          match_cnt <= '0;
        end else begin
          match_cnt  <= match_next;
          prev_bcd   <= frame_bcd;
          prev_blank <= frame_blank;
          if (match_next >= MATCH_LIM) begin
            bcd_out    <= frame_bcd;
            blank_mask <= frame_blank;
            valid      <= 1'b1;
          end
        end
      end
    end
  end

  cnt_w_fits : assert property (@(posedge clk) CNT_FITS);

endmodule
